// File: rtl/spram_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spram_loader
//
// Byte-stream loader that masters a 32-bit SPRAM bank. Bytes arriving on a
// valid/ready handshake are packed little-endian into 32-bit words. Each word
// is written to consecutive word addresses with a byte-select mask. A running
// modulo-2^16 sum of the accepted bytes is kept. The block is used to load the
// eForth image into SPRAM after configuration, before the core is released.
//
// Optional feature macro: LDR_VERIFY_EN
//   When defined, every write is followed by a read-back (VRD) and a masked
//   compare (VCMP). A mismatch sets the sticky err flag. When undefined, err is
//   tied to 0 and mem_vo is ignored.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle load request; ignored while busy
//   addr0     in   [AW-1:0] first word address, sampled on an accepted start
//   nbytes    in   [17:0]   byte count 0..131072, sampled on an accepted start
//   byte_i    in   [7:0]    stream byte
//   byte_vld  in   byte_i is valid
//   byte_rdy  out  loader accepts byte_i this cycle
//   mem_ai    out  [AW-1:0] SPRAM word address
//   mem_vi    out  [31:0]   SPRAM write data
//   mem_bmsk  out  [3:0]    byte mask; bit n enables bits [8n+7:8n]
//   mem_we    out  SPRAM write strobe
//   mem_vo    in   [31:0]   SPRAM read data, valid one cycle after address
//   busy      out  a load is in progress
//   done      out  one-cycle pulse when a load completes
//   err       out  sticky verify mismatch
//   sum       out  [15:0]   modulo-2^16 sum of accepted bytes
// -----------------------------------------------------------------------------
module spram_loader #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] addr0,
    input  logic [17:0]   nbytes,
    input  logic [7:0]    byte_i,
    input  logic          byte_vld,
    output logic          byte_rdy,
    output logic [AW-1:0] mem_ai,
    output logic [31:0]   mem_vi,
    output logic [3:0]    mem_bmsk,
    output logic          mem_we,
    input  logic [31:0]   mem_vo,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WR,
`ifdef LDR_VERIFY_EN
        S_VRD,
        S_VCMP,
`endif
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] addr_q;
    logic [31:0]   word_q;
    logic [3:0]    bmsk_q;
    logic [1:0]    lane_q;
    logic [17:0]   remaining_q;
    logic [15:0]   sum_q;

    logic          accept_start;
    logic          fill_hs;
    logic          word_full;
    logic          bytes_left;
    logic          write_end;

    // A start is only honoured from IDLE; anywhere else it is dropped.
    assign accept_start = (state == S_IDLE) && start;

    // byte_rdy is a pure decode of the state register, so a handshake is
    // simply FILL plus byte_vld.
    assign fill_hs      = (state == S_FILL) && byte_vld;

    // The word closes on lane 3 or on the last byte of the load.
    assign word_full    = (lane_q == 2'd3) || (remaining_q == 18'd1);
    assign bytes_left   = (remaining_q != 18'd0);

    // The write sequence ends at the cycle that hands control back to FILL or
    // DONE; that is when the address advances and the word register clears.
`ifdef LDR_VERIFY_EN
    assign write_end    = (state == S_VCMP);
`else
    assign write_end    = (state == S_WR);
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_next is defaulted before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (nbytes != 18'd0) ? S_FILL : S_DONE;
                end
            end
            S_FILL: begin
                if (byte_vld && word_full) begin
                    state_next = S_WR;
                end
            end
            S_WR: begin
`ifdef LDR_VERIFY_EN
                state_next = S_VRD;
`else
                state_next = bytes_left ? S_FILL : S_DONE;
`endif
            end
`ifdef LDR_VERIFY_EN
            S_VRD: begin
                // Address is held with mem_we low; read data lands next cycle.
                state_next = S_VCMP;
            end
            S_VCMP: begin
                state_next = bytes_left ? S_FILL : S_DONE;
            end
`endif
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: address, word packing, mask, lane, remaining count and sum
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            word_q      <= '0;
            bmsk_q      <= '0;
            lane_q      <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
        end else if (accept_start) begin
            addr_q      <= addr0;
            word_q      <= '0;
            bmsk_q      <= '0;
            lane_q      <= '0;
            remaining_q <= nbytes;
            sum_q       <= '0;
        end else if (fill_hs) begin
            word_q[{lane_q, 3'b000} +: 8] <= byte_i;
            bmsk_q[lane_q]                <= 1'b1;
            lane_q                        <= lane_q + 2'd1;
            remaining_q                   <= remaining_q - 18'd1;
            sum_q                         <= sum_q + {8'h00, byte_i};
        end else if (write_end) begin
            // Address wraps modulo 2^AW; unfilled lanes of the next word must
            // start as data 0 with mask 0.
            addr_q <= addr_q + AW'(1);
            word_q <= '0;
            bmsk_q <= '0;
            lane_q <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Read-back verify
    // -------------------------------------------------------------------------
`ifdef LDR_VERIFY_EN
    logic        err_q;
    logic [31:0] cmp_mask;

    assign cmp_mask = {{8{bmsk_q[3]}}, {8{bmsk_q[2]}},
                       {8{bmsk_q[1]}}, {8{bmsk_q[0]}}};

    // Sticky across the load; only a new accepted start clears it. A mismatch
    // is recorded but the load carries on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept_start) begin
            err_q <= 1'b0;
        end else if ((state == S_VCMP) &&
                     (((mem_vo ^ word_q) & cmp_mask) != 32'd0)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_mem_vo;

    assign unused_mem_vo = ^mem_vo;
    assign err           = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: all come straight from flops or from decodes of the state flop
    // -------------------------------------------------------------------------
    assign byte_rdy = (state == S_FILL);
    assign mem_we   = (state == S_WR);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign mem_ai   = addr_q;
    assign mem_vi   = word_q;
    assign mem_bmsk = bmsk_q;
    assign sum      = sum_q;

endmodule
